// File: rtl/div_clk_chk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_clk_chk_pkg
//  Description : Shared types and default constants for the divided-clock
//                checker (FSM states, default parameters, error count width).
//  Revision    : 1.0 - initial release
// ============================================================================
package div_clk_chk_pkg;

    // Measurement FSM: IDLE waits for activity, SKIP drops the first
    // (possibly partial) period, RUN measures every completed period.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SKIP = 2'd1,
        ST_RUN  = 2'd2
    } chk_state_t;

    localparam int C_CNT_W_DEF      = 8;
    localparam int C_EXP_PERIOD_DEF = 3;
    localparam int C_HIGH_MIN_DEF   = 1;
    localparam int C_HIGH_MAX_DEF   = 2;
    localparam int C_LOCK_N_DEF     = 4;
    localparam int C_TIMEOUT_DEF    = 16;

    // Width of the saturating error counter exported to status logic.
    localparam int C_ERR_CNT_W      = 8;

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
//  Module      : sync2
//  Description : Two-flop synchronizer for a single asynchronous bit, with
//                synchronous active-high reset to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops give the first stage a full cycle to resolve.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/div_clk_checker.sv
`default_nettype none
// ============================================================================
//  Module      : div_clk_checker
//  Description : Samples a divided clock as data, measures high/low run
//                lengths per period, checks period and high-time window,
//                reports lock, error pulses and a saturating error count.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_clk_checker
    import div_clk_chk_pkg::*;
#(
    parameter int CNT_W      = C_CNT_W_DEF,
    parameter int EXP_PERIOD = C_EXP_PERIOD_DEF,
    parameter int HIGH_MIN   = C_HIGH_MIN_DEF,
    parameter int HIGH_MAX   = C_HIGH_MAX_DEF,
    parameter int LOCK_N     = C_LOCK_N_DEF,
    parameter int TIMEOUT    = C_TIMEOUT_DEF
) (
    input  logic                   clkin,
    input  logic                   rst,
    input  logic                   mon_in,
    output logic [CNT_W-1:0]       high_cnt,
    output logic [CNT_W-1:0]       low_cnt,
    output logic                   meas_valid,
    output logic                   locked,
    output logic                   err,
    output logic [C_ERR_CNT_W-1:0] err_cnt
);

    localparam int GOOD_W = $clog2(LOCK_N + 1);

    // ------------------------------------------------------------------
    // Synchronizer, delay flop and edge detection
    // ------------------------------------------------------------------
    logic w_s;
    logic r_s_d;
    logic w_rise;
    logic w_fall;

    sync2 u_sync2 (
        .clk (clkin),
        .rst (rst),
        .d   (mon_in),
        .q   (w_s)
    );

    assign w_rise = w_s & ~r_s_d;
    assign w_fall = ~w_s & r_s_d;

    // ------------------------------------------------------------------
    // Run-length counters: value after update = length of current run
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_hc;
    logic [CNT_W-1:0] r_lc;
    logic [CNT_W-1:0] w_hc_next;
    logic [CNT_W-1:0] w_lc_next;

    // Reload on the run's first cycle, otherwise count up and stick at max.
    always_comb begin
        w_hc_next = r_hc;
        w_lc_next = r_lc;
        if (w_rise) begin
            w_hc_next = CNT_W'(1);
        end else if (w_s && (r_hc != '1)) begin
            w_hc_next = r_hc + CNT_W'(1);
        end
        if (w_fall) begin
            w_lc_next = CNT_W'(1);
        end else if (!w_s && (r_lc != '1)) begin
            w_lc_next = r_lc + CNT_W'(1);
        end
    end

    // Stuck detection looks at the run length including this cycle, so a
    // run hits TIMEOUT exactly once and a stale count from a finished run
    // can never trigger it.
    logic w_run_timeout;
    assign w_run_timeout = w_s ? (w_hc_next == CNT_W'(TIMEOUT))
                               : (w_lc_next == CNT_W'(TIMEOUT));

    // On a rise, r_hc still holds the previous high run and r_lc the low
    // run that just ended: together they form the completed period.
    logic [CNT_W:0] w_sum;
    logic           w_period_ok;
    assign w_sum       = {1'b0, r_hc} + {1'b0, r_lc};
    assign w_period_ok = (w_sum == (CNT_W+1)'(EXP_PERIOD))
                      && (r_hc >= CNT_W'(HIGH_MIN))
                      && (r_hc <= CNT_W'(HIGH_MAX));

    // ------------------------------------------------------------------
    // Measurement FSM
    // ------------------------------------------------------------------
    chk_state_t r_state;
    chk_state_t w_state_next;
    logic       w_meas;
    logic       w_good;
    logic       w_bad;
    logic       w_stuck;

    // State register.
    always_ff @(posedge clkin) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and per-cycle events; a timeout outranks a coincident rise.
    always_comb begin
        w_state_next = r_state;
        w_meas       = 1'b0;
        w_good       = 1'b0;
        w_bad        = 1'b0;
        w_stuck      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_next = ST_SKIP;
                end
            end
            ST_SKIP: begin
                if (w_run_timeout) begin
                    w_stuck      = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (w_rise) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_run_timeout) begin
                    w_stuck      = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (w_rise) begin
                    w_meas = 1'b1;
                    w_good = w_period_ok;
                    w_bad  = ~w_period_ok;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Good-run counter and registered status outputs
    // ------------------------------------------------------------------
    logic [GOOD_W-1:0] r_good;
    logic [GOOD_W-1:0] w_good_next;
    logic              w_err;

    assign w_err = w_bad | w_stuck;

    // Any error restarts the lock qualification; good periods count up to LOCK_N.
    always_comb begin
        w_good_next = r_good;
        if (w_err) begin
            w_good_next = '0;
        end else if (w_good && (r_good != GOOD_W'(LOCK_N))) begin
            w_good_next = r_good + GOOD_W'(1);
        end
    end

    // Register counters, measurements, lock and error status.
    always_ff @(posedge clkin) begin
        if (rst) begin
            r_s_d      <= 1'b0;
            r_hc       <= '0;
            r_lc       <= '0;
            r_good     <= '0;
            high_cnt   <= '0;
            low_cnt    <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            err        <= 1'b0;
            err_cnt    <= '0;
        end else begin
            r_s_d      <= w_s;
            r_hc       <= w_hc_next;
            r_lc       <= w_lc_next;
            r_good     <= w_good_next;
            meas_valid <= w_meas;
            err        <= w_err;
            locked     <= (w_good_next == GOOD_W'(LOCK_N));
            if (w_meas) begin
                high_cnt <= r_hc;
                low_cnt  <= r_lc;
            end
            if (w_err && (err_cnt != '1)) begin
                err_cnt <= err_cnt + C_ERR_CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_clk_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_clk_checker
//  Description : Directed self-checking bench for div_clk_checker. One
//                instance uses default parameters, a second one uses
//                EXP_PERIOD=4 for the high-time window case.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_clk_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       mon_in;
    logic       mon4;

    logic [7:0] high_cnt, low_cnt, err_cnt;
    logic       meas_valid, locked, err;
    logic [7:0] high4, low4, errc4;
    logic       meas4, locked4, err4;

    int n_checks = 0;
    int n_fail   = 0;

    int n_meas, n_err, last_hi, last_lo;
    int n_meas4, n_err4, last_hi4, last_lo4;

    always #5 clk = ~clk;

    div_clk_checker u_dut (
        .clkin      (clk),
        .rst        (rst),
        .mon_in     (mon_in),
        .high_cnt   (high_cnt),
        .low_cnt    (low_cnt),
        .meas_valid (meas_valid),
        .locked     (locked),
        .err        (err),
        .err_cnt    (err_cnt)
    );

    div_clk_checker #(.EXP_PERIOD(4)) u_dut4 (
        .clkin      (clk),
        .rst        (rst),
        .mon_in     (mon4),
        .high_cnt   (high4),
        .low_cnt    (low4),
        .meas_valid (meas4),
        .locked     (locked4),
        .err        (err4),
        .err_cnt    (errc4)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        n_meas = 0; n_err = 0; last_hi = -1; last_lo = -1;
        n_meas4 = 0; n_err4 = 0; last_hi4 = -1; last_lo4 = -1;
    endtask

    // One clkin cycle: drive inputs, then sample outputs 1 time unit after the edge.
    task automatic step(input logic v, input logic v4);
        mon_in = v;
        mon4   = v4;
        @(posedge clk);
        #1;
        if (meas_valid) begin n_meas++; last_hi = high_cnt; last_lo = low_cnt; end
        if (err) n_err++;
        if (meas4) begin n_meas4++; last_hi4 = high4; last_lo4 = low4; end
        if (err4) n_err4++;
    endtask

    task automatic period(input int hi, input int lo);
        for (int i = 0; i < hi; i++) step(1'b1, 1'b0);
        for (int i = 0; i < lo; i++) step(1'b0, 1'b0);
    endtask

    task automatic period4(input int hi, input int lo);
        for (int i = 0; i < hi; i++) step(1'b0, 1'b1);
        for (int i = 0; i < lo; i++) step(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst = 1'b0;
        clear_mon();
    endtask

    initial begin
        rst    = 1'b1;
        mon_in = 1'b0;
        mon4   = 1'b0;
        clear_mon();

        // Reset state
        do_reset();
        check_val("rst_high_cnt", int'(high_cnt), 0);
        check_val("rst_low_cnt",  int'(low_cnt),  0);
        check_val("rst_meas",     int'(meas_valid), 0);
        check_val("rst_locked",   int'(locked), 0);
        check_val("rst_err",      int'(err), 0);
        check_val("rst_err_cnt",  int'(err_cnt), 0);

        // High time out of window: EXP_PERIOD=4, pattern 1,1,1,0
        for (int p = 0; p < 6; p++) period4(3, 1);
        check_val("w4_meas",    n_meas4, 4);
        check_val("w4_err",     n_err4, 4);
        check_val("w4_err_cnt", int'(errc4), 4);
        check_val("w4_hi",      last_hi4, 3);
        check_val("w4_lo",      last_lo4, 1);
        check_val("w4_locked",  int'(locked4), 0);
        clear_mon();
        // 2/2 fits the window: only the first (3,1) measurement is bad
        for (int p = 0; p < 5; p++) period4(2, 2);
        check_val("w4_ok_err",    n_err4, 1);
        check_val("w4_ok_hi",     last_hi4, 2);
        check_val("w4_ok_lo",     last_lo4, 2);
        check_val("w4_ok_locked", int'(locked4), 1);
        check_val("w4_ok_errcnt", int'(errc4), 5);

        // Divide-by-3 pattern 1,1,0
        do_reset();
        period(2, 1);
        period(2, 1);
        check_val("div3_skip", n_meas, 0);
        for (int p = 3; p <= 8; p++) begin
            period(2, 1);
            check_val("div3_hi", last_hi, 2);
            check_val("div3_lo", last_lo, 1);
            if (p == 5) check_val("div3_lock_early", int'(locked), 0);
            if (p == 6) check_val("div3_lock", int'(locked), 1);
        end
        check_val("div3_meas",    n_meas, 6);
        check_val("div3_err",     n_err, 0);
        check_val("div3_err_cnt", int'(err_cnt), 0);

        // Short period 1,0 while locked
        clear_mon();
        period(1, 1);
        period(2, 1);
        check_val("short_hi",      last_hi, 1);
        check_val("short_lo",      last_lo, 1);
        check_val("short_err",     n_err, 1);
        check_val("short_err_cnt", int'(err_cnt), 1);
        check_val("short_unlock",  int'(locked), 0);
        for (int p = 0; p < 3; p++) period(2, 1);
        check_val("short_relock_early", int'(locked), 0);
        period(2, 1);
        check_val("short_relock", int'(locked), 1);

        // Stuck high for 20 cycles
        clear_mon();
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check_val("stuck_err",     n_err, 1);
        check_val("stuck_err_cnt", int'(err_cnt), 2);
        check_val("stuck_locked",  int'(locked), 0);
        clear_mon();
        period(2, 1);
        period(2, 1);
        check_val("stuck_idle", n_meas, 0);
        for (int p = 0; p < 6; p++) period(2, 1);
        check_val("stuck_relock", int'(locked), 1);
        check_val("stuck_no_err", n_err, 0);

        // Reset mid-run while locked with mon_in high
        rst = 1'b1;
        step(1'b1, 1'b0);
        check_val("mrst_high_cnt", int'(high_cnt), 0);
        check_val("mrst_low_cnt",  int'(low_cnt), 0);
        check_val("mrst_meas",     int'(meas_valid), 0);
        check_val("mrst_locked",   int'(locked), 0);
        check_val("mrst_err",      int'(err), 0);
        check_val("mrst_err_cnt",  int'(err_cnt), 0);
        rst = 1'b0;
        clear_mon();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        period(2, 1);
        check_val("mrst_no_meas", n_meas, 0);
        period(2, 1);
        check_val("mrst_meas_cnt", n_meas, 1);
        check_val("mrst_hi",       last_hi, 2);
        check_val("mrst_lo",       last_lo, 1);
        check_val("mrst_unlocked", int'(locked), 0);
        check_val("mrst_no_err",   n_err, 0);

        // Saturation: 300 bad periods
        clear_mon();
        for (int p = 0; p < 300; p++) period(1, 1);
        period(2, 1);
        check_val("sat_err_cnt", int'(err_cnt), 255);
        check_val("sat_err",     n_err, 300);
        check_val("sat_hi",      last_hi, 1);
        check_val("sat_lo",      last_lo, 1);
        check_val("sat_locked",  int'(locked), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
